// File: rtl/if_dc_skid_if.sv
// if_dc_skid_if: valid/ready handshake carrying an instruction word and its next-PC
interface if_dc_skid_if #(parameter int DW = 32, parameter int PW = 32);
  logic          valid;
  logic          ready;
  logic [DW-1:0] imemload;
  logic [PW-1:0] npc;
  modport master(output valid, imemload, npc, input ready);
  modport slave(input valid, imemload, npc, output ready);
endinterface

// File: rtl/if_dc_skid.sv
// if_dc_skid: IF->DC pipeline register with a 2-entry skid buffer and flush
module if_dc_skid #(
  parameter int DW            = 32,
  parameter int PW            = 32,
  parameter bit FLUSH_KEEP_PC = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        flush,
  if_dc_skid_if.slave  fetch,
  if_dc_skid_if.master decode,
  output logic [1:0]  occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t        state, state_n;
  logic [DW-1:0] main_instr, main_instr_n, skid_instr, skid_instr_n;
  logic [PW-1:0] main_npc, main_npc_n, skid_npc, skid_npc_n;
  logic          in_fire, out_fire;
  assign fetch.ready     = state != FULL;
  assign decode.valid    = state != EMPTY;
  assign decode.imemload = main_instr;
  assign decode.npc      = main_npc;
  assign occupancy       = state;
  assign in_fire         = fetch.valid & fetch.ready;
  assign out_fire        = decode.valid & decode.ready;
  // state and storage registers; reset clears everything asynchronously
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= EMPTY;
      main_instr <= '0;
      main_npc   <= '0;
      skid_instr <= '0;
      skid_npc   <= '0;
    end else begin
      state      <= state_n;
      main_instr <= main_instr_n;
      main_npc   <= main_npc_n;
      skid_instr <= skid_instr_n;
      skid_npc   <= skid_npc_n;
    end
  end
  // next state and storage moves; flush overrides every handshake in its cycle
  always_comb begin
    state_n      = state;
    main_instr_n = main_instr;
    main_npc_n   = main_npc;
    skid_instr_n = skid_instr;
    skid_npc_n   = skid_npc;
    if (flush) begin
      state_n      = EMPTY;
      main_instr_n = '0;
      main_npc_n   = FLUSH_KEEP_PC ? main_npc : '0;
      skid_instr_n = '0;
      skid_npc_n   = '0;
    end else begin
      unique case (state)
        EMPTY: if (in_fire) begin
          state_n      = ONE;
          main_instr_n = fetch.imemload;
          main_npc_n   = fetch.npc;
        end
        ONE: if (in_fire && !out_fire) begin
          state_n      = FULL;
          skid_instr_n = fetch.imemload;
          skid_npc_n   = fetch.npc;
        end else if (in_fire) begin
          main_instr_n = fetch.imemload;
          main_npc_n   = fetch.npc;
        end else if (out_fire) begin
          state_n = EMPTY;
        end
        FULL: if (out_fire) begin
          state_n      = ONE;
          main_instr_n = skid_instr;
          main_npc_n   = skid_npc;
        end
        default: state_n = EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_if_dc_skid.sv
// tb_if_dc_skid: scoreboard bench for if_dc_skid with both flush PC policies
module tb_if_dc_skid;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        flush = 1'b0;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic [31:0] di = '0;
  logic [31:0] pi = '0;
  logic [1:0]  occ1, occ0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] q[$];
  if_dc_skid_if f1(), d1(), f0(), d0();
  assign f1.valid = iv;
  assign f1.imemload = di;
  assign f1.npc = pi;
  assign f0.valid = iv;
  assign f0.imemload = di;
  assign f0.npc = pi;
  assign d1.ready = ordy;
  assign d0.ready = ordy;
  if_dc_skid #(.DW(32), .PW(32), .FLUSH_KEEP_PC(1'b1)) u1 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .fetch(f1), .decode(d1), .occupancy(occ1));
  if_dc_skid #(.DW(32), .PW(32), .FLUSH_KEEP_PC(1'b0)) u0 (
    .CLK(CLK), .nRST(nRST), .flush(flush), .fetch(f0), .decode(d0), .occupancy(occ0));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // called mid low phase: checks outputs against the model, then advances one cycle
  task automatic tick();
    logic inf, outf;
    logic [63:0] h;
    int n;
    n = q.size();
    chk("occ1", 64'(occ1), 64'(n));
    chk("occ0", 64'(occ0), 64'(n));
    chk("in_ready", 64'(f1.ready), 64'(n < 2));
    chk("out_valid", 64'(d1.valid), 64'(n != 0));
    if (n != 0) begin
      h = q[0];
      chk("head1", {d1.imemload, d1.npc}, h);
      chk("head0", {d0.imemload, d0.npc}, h);
    end
    inf = iv && n < 2;
    outf = ordy && n != 0;
    if (flush) q.delete();
    else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({di, pi});
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic push(input logic [31:0] d, input logic [31:0] p);
    iv = 1'b1;
    di = d;
    pi = p;
    tick();
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_valid", 64'(d1.valid), 64'd0);
    chk("rst_ready", 64'(f1.ready), 64'd1);
    nRST = 1'b1;
    @(negedge CLK);
    ordy = 1'b1;
    push(32'h11, 32'h104);
    push(32'h22, 32'h108);
    push(32'h33, 32'h10c);
    iv = 1'b0;
    chk("stream_occ", 64'(occ1), 64'd1);
    chk("stream_last", 64'(d1.imemload), 64'h33);
    tick();
    ordy = 1'b0;
    push(32'hA0, 32'h200);
    push(32'hB0, 32'h204);
    chk("skid_occ", 64'(occ1), 64'd2);
    chk("skid_ready", 64'(f1.ready), 64'd0);
    push(32'hC0, 32'h208);
    chk("skid_c0_held", 64'(q.size()), 64'd2);
    ordy = 1'b1;
    chk("pop_a0", 64'(d1.imemload), 64'hA0);
    tick();
    tick();
    iv = 1'b0;
    repeat (3) tick();
    ordy = 1'b0;
    push(32'hA4, 32'h104);
    push(32'hB4, 32'h108);
    iv = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(d1.valid), 64'd0);
    chk("flush_instr", 64'(d1.imemload), 64'd0);
    chk("flush_keep_npc", 64'(d1.npc), 64'h104);
    chk("flush_occ", 64'(occ1), 64'd0);
    chk("flush_zero_npc", 64'(d0.npc), 64'd0);
    push(32'hDEAD, 32'h300);
    iv = 1'b0;
    flush = 1'b1;
    ordy = 1'b1;
    tick();
    flush = 1'b0;
    chk("dead_valid", 64'(d1.valid), 64'd0);
    push(32'hBEEF, 32'h400);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    iv = 1'b0;
    chk("flush_in_fire_instr", 64'(d1.imemload), 64'd0);
    chk("flush_in_fire_valid", 64'(d1.valid), 64'd0);
    repeat (2) tick();
    ordy = 1'b0;
    push(32'h55, 32'h500);
    push(32'h66, 32'h504);
    iv = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("arst_valid", 64'(d1.valid), 64'd0);
    chk("arst_ready", 64'(f1.ready), 64'd1);
    chk("arst_instr", 64'(d1.imemload), 64'd0);
    chk("arst_npc", 64'(d1.npc), 64'd0);
    chk("arst_occ", 64'(occ1), 64'd0);
    q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      iv = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 63) == 0);
      di = $urandom;
      pi = $urandom;
      tick();
    end
    iv = 1'b0;
    flush = 1'b0;
    ordy = 1'b1;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
